// File: rtl/audio_pkg.sv
// Shared audio types and I2S framing constants.
package audio_pkg;

  typedef logic signed [15:0] sample_t;

  localparam int unsigned I2S_SLOT_BITS  = 16;
  localparam int unsigned I2S_FRAME_BITS = 32;
  localparam int unsigned SLOT_CNT_W     = $clog2(I2S_FRAME_BITS);

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } channel_e;

  // Slot offset k within a channel carries word bit (16-k) mod 16, so the
  // MSB lands one BCLK after the LRCK edge and the LSB spills into the next slot.
  function automatic logic [3:0] tx_bit_index(input logic [SLOT_CNT_W-1:0] slot);
    logic [4:0] diff;
    diff = 5'd16 - {1'b0, slot[3:0]};
    return diff[3:0];
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Sample FIFO with pointer-extension full/empty, synchronous flush.
module sample_fifo
  import audio_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic    Clk,
  input  logic    Reset,
  input  logic    flush,
  input  logic    push,
  input  logic    pop,
  input  sample_t din,
  output sample_t dout,
  output logic    full,
  output logic    empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  sample_t        mem [DEPTH];
  logic    [AW:0] wr_ptr;
  logic    [AW:0] rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop frees a slot in the same cycle, so a full FIFO can still take a push.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge Clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/i2s_tx.sv
// I2S mono transmitter: one FIFO word per frame, sent on both channels.
// Optional macro I2S_TX_UNDERFLOW_CNT_EN adds a saturating underflow_count output.
module i2s_tx
  import audio_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Enable,
  input  sample_t     sample_in,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        AUD_BCLK,
  output logic        AUD_DACLRCK,
  output logic        AUD_DACDAT,
  output logic        underflow
`ifdef I2S_TX_UNDERFLOW_CNT_EN
  ,
  output logic [15:0] underflow_count
`endif
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0]            div_cnt;
  logic [SLOT_CNT_W-1:0] slot;
  logic [SLOT_CNT_W-1:0] slot_next;
  channel_e              ch_next;
  sample_t               cur_word;
  sample_t               fifo_dout;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  bclk_tick;
  logic                  bclk_fall;
  logic                  frame_start;
  logic                  uf_next;

  always_comb begin
    bclk_tick   = (div_cnt == DIV_LAST);
    bclk_fall   = bclk_tick && AUD_BCLK;
    slot_next   = slot + SLOT_CNT_W'(1);
    ch_next     = slot_next[SLOT_CNT_W-1] ? CH_RIGHT : CH_LEFT;
    frame_start = bclk_fall && (slot == '1);
    uf_next     = frame_start && Enable && fifo_empty;
  end

  assign sample_ready = Enable && !fifo_full;
  assign fifo_push    = sample_valid && sample_ready;
  assign fifo_pop     = frame_start && Enable && !fifo_empty;

  sample_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .Clk   (Clk),
    .Reset (Reset),
    .flush (!Enable),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (sample_in),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      div_cnt     <= '0;
      AUD_BCLK    <= 1'b0;
      slot        <= '1;
      AUD_DACLRCK <= 1'b1;
      AUD_DACDAT  <= 1'b0;
      underflow   <= 1'b0;
      cur_word    <= '0;
    end else begin
      underflow <= uf_next;
      if (bclk_tick) begin
        div_cnt  <= '0;
        AUD_BCLK <= !AUD_BCLK;
      end else begin
        div_cnt <= div_cnt + 8'd1;
      end
      // At a frame start this still reads the previous word, which supplies
      // the right-channel LSB in slot 0 before the new word is loaded.
      if (bclk_fall) begin
        slot        <= slot_next;
        AUD_DACLRCK <= ch_next;
        AUD_DACDAT  <= Enable && cur_word[tx_bit_index(slot_next)];
      end
      if (!Enable) begin
        cur_word <= '0;
      end else if (frame_start) begin
        cur_word <= fifo_empty ? '0 : fifo_dout;
      end
    end
  end

`ifdef I2S_TX_UNDERFLOW_CNT_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      underflow_count <= '0;
    end else if (uf_next && (underflow_count != '1)) begin
      underflow_count <= underflow_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: frame-arithmetic reference model checked every cycle, plus directed cases.
module tb_i2s_tx;
  import audio_pkg::*;

  localparam int CLK_DIV = 4;
  localparam int DEPTH   = 8;
  localparam int FALL_CYC  = 2 * CLK_DIV;
  localparam int FRAME_CYC = 64 * CLK_DIV;

  logic    Clk = 1'b0;
  logic    Reset = 1'b1;
  logic    Enable = 1'b1;
  logic    sample_valid = 1'b0;
  sample_t sample_in = '0;
  logic    sample_ready;
  logic    AUD_BCLK;
  logic    AUD_DACLRCK;
  logic    AUD_DACDAT;
  logic    underflow;
`ifdef I2S_TX_UNDERFLOW_CNT_EN
  logic [15:0] underflow_count;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  i2s_tx #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Enable       (Enable),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .AUD_BCLK     (AUD_BCLK),
    .AUD_DACLRCK  (AUD_DACLRCK),
    .AUD_DACDAT   (AUD_DACDAT),
    .underflow    (underflow)
`ifdef I2S_TX_UNDERFLOW_CNT_EN
    ,
    .underflow_count (underflow_count)
`endif
  );

  always #5 Clk = ~Clk;

  // Reference model state: Clk edges since reset release, sample queue, frame words.
  int          cyc;
  sample_t     q[$];
  sample_t     fw_cur;
  sample_t     fw_prev;
  logic        m_dat;
  logic        m_uf;
  logic [15:0] m_cnt;
  int          m_slot;
  int          m_falls;
  bit          m_is_fall;
  bit          m_ready_pre;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Slot 0 carries the LSB of the previous frame's word, slot 16 the LSB of
  // the current one; any other slot s carries bit 16 - (s mod 16).
  function automatic logic bit_of_slot(input int s);
    int k;
    k = s % 16;
    if (s == 0) return fw_prev[0];
    if (k == 0) return fw_cur[0];
    return fw_cur[16 - k];
  endfunction

  always @(posedge Clk) begin
    if (Reset) begin
      cyc = 0;
      q.delete();
      fw_cur  = '0;
      fw_prev = '0;
      m_dat   = 1'b0;
      m_uf    = 1'b0;
      m_cnt   = '0;
    end else begin
      m_ready_pre = Enable && (q.size() < DEPTH);
      cyc++;
      m_is_fall = (cyc % FALL_CYC) == 0;
      m_falls   = cyc / FALL_CYC;
      m_slot    = (m_falls + 31) % 32;
      m_uf      = 1'b0;
      if (m_is_fall) begin
        if (m_slot == 0) begin
          fw_prev = fw_cur;
          if (!Enable) begin
            fw_cur = '0;
          end else if (q.size() == 0) begin
            fw_cur = '0;
            m_uf   = 1'b1;
            if (m_cnt != 16'hFFFF) m_cnt++;
          end else begin
            fw_cur = q.pop_front();
          end
        end
        m_dat = Enable && bit_of_slot(m_slot);
      end
      if (sample_valid && m_ready_pre) q.push_back(sample_in);
      if (!Enable) begin
        q.delete();
        fw_cur = '0;
      end
      #1;
      if (!Reset) begin
        check("bclk",  32'(AUD_BCLK),    32'((cyc / CLK_DIV) % 2));
        check("lrck",  32'(AUD_DACLRCK), 32'(m_slot >= 16));
        check("dat",   32'(AUD_DACDAT),  32'(m_dat));
        check("uflow", 32'(underflow),   32'(m_uf));
        check("ready", 32'(sample_ready), 32'(Enable && (q.size() < DEPTH)));
`ifdef I2S_TX_UNDERFLOW_CNT_EN
        check("ucount", 32'(underflow_count), 32'(m_cnt));
`endif
      end
    end
  end

  task automatic wait_cyc(input int t);
    int guard;
    guard = 0;
    while (cyc < t && guard < 20000) begin
      @(negedge Clk);
      guard++;
    end
    if (cyc < t) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wait_cyc: got cyc %0d required %0d", cyc, t);
    end
  endtask

  task automatic do_reset;
    @(negedge Clk);
    Reset        = 1'b1;
    sample_valid = 1'b0;
    sample_in    = '0;
    Enable       = 1'b1;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
  endtask

  // Samples DACDAT mid-period (BCLK high) for each of the 32 slots of frame f.
  task automatic capture_frame(input int f, output logic [31:0] bits);
    bits = '0;
    for (int s = 0; s < 32; s++) begin
      wait_cyc(FALL_CYC * (32 * f + 1 + s) + CLK_DIV);
      bits[31-s] = AUD_DACDAT;
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_bclk"},  32'(AUD_BCLK),     32'd0);
    check({tag, "_lrck"},  32'(AUD_DACLRCK),  32'd1);
    check({tag, "_dat"},   32'(AUD_DACDAT),   32'd0);
    check({tag, "_uflow"}, 32'(underflow),    32'd0);
    check({tag, "_ready"}, 32'(sample_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] bits;
    int acc;
    int uf_cnt;
    int uf_first;
    int uf_last;
    int d_or;

    #12;
    check_reset_values("rst");

    // Single word 0x8001 right after reset.
    do_reset();
    sample_valid = 1'b1;
    sample_in    = sample_t'(16'h8001);
    @(negedge Clk);
    sample_valid = 1'b0;
    capture_frame(0, bits);
    check("frame_8001", bits, 32'h4000C000);
    check("word_8001", 32'({bits[30:16], bits[15]}), 32'h8001);

    // Fill the FIFO within one frame: exactly DEPTH accepts.
    do_reset();
    wait_cyc(19);
    acc = 0;
    for (int i = 0; i < 12; i++) begin
      sample_valid = 1'b1;
      sample_in    = sample_t'(16'h0100 + i);
      if (sample_ready) acc++;
      @(negedge Clk);
    end
    sample_valid = 1'b0;
    check("fill_accepts", 32'(acc), 32'd8);
    check("fill_ready", 32'(sample_ready), 32'd0);
    capture_frame(1, bits);
    check("fill_first_word", 32'({bits[30:16], bits[15]}), 32'h0100);

    // No samples: underflow once per frame, data stays zero.
    do_reset();
    uf_cnt = 0; uf_first = 0; uf_last = 0; d_or = 0;
    for (int i = 0; i < 8 + 2 * FRAME_CYC + 20; i++) begin
      @(negedge Clk);
      if (underflow) begin
        uf_cnt++;
        if (uf_cnt == 1) uf_first = cyc;
        uf_last = cyc;
      end
      d_or = d_or | 32'(AUD_DACDAT);
    end
    check("uf_count", 32'(uf_cnt), 32'd3);
    check("uf_first", 32'(uf_first), 32'd8);
    check("uf_period", 32'(uf_last - uf_first), 32'(2 * FRAME_CYC));
    check("uf_dat_zero", 32'(d_or), 32'd0);
`ifdef I2S_TX_UNDERFLOW_CNT_EN
    check("uf_counter", 32'(underflow_count), 32'd3);
`endif

    // One word buffered, push coincides with the frame-start pop.
    do_reset();
    @(negedge Clk);
    sample_valid = 1'b1;
    sample_in    = sample_t'(16'h1234);
    @(negedge Clk);
    sample_valid = 1'b0;
    wait_cyc(7);
    sample_valid = 1'b1;
    sample_in    = sample_t'(16'hABCD);
    @(negedge Clk);
    sample_valid = 1'b0;
    capture_frame(0, bits);
    check("pp_word0", 32'({bits[30:16], bits[15]}), 32'h1234);
    capture_frame(1, bits);
    check("pp_word1", 32'({bits[30:16], bits[15]}), 32'hABCD);

    // Enable drop mid-frame with 4 words still buffered.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      sample_valid = 1'b1;
      sample_in    = sample_t'(16'hFFFF - i);
      @(negedge Clk);
    end
    sample_valid = 1'b0;
    wait_cyc(50);
    Enable = 1'b0;
    @(negedge Clk);
    check("dis_ready", 32'(sample_ready), 32'd0);
    wait_cyc(57);
    uf_cnt = 0; d_or = 0;
    while (cyc < 400) begin
      @(negedge Clk);
      d_or = d_or | 32'(AUD_DACDAT);
      if (underflow) uf_cnt++;
    end
    check("dis_dat_zero", 32'(d_or), 32'd0);
    check("dis_no_uflow", 32'(uf_cnt), 32'd0);
    Enable = 1'b1;
    uf_first = 0;
    while (cyc < 540) begin
      @(negedge Clk);
      if (underflow) begin
        uf_cnt++;
        uf_first = cyc;
      end
    end
    check("reen_uflow", 32'(uf_cnt), 32'd1);
    check("reen_uflow_at", 32'(uf_first), 32'(8 + 2 * FRAME_CYC));

    // Asynchronous reset during the bit-7 slot, between Clk edges.
    do_reset();
    sample_valid = 1'b1;
    sample_in    = sample_t'(16'hFFFF);
    @(negedge Clk);
    sample_valid = 1'b0;
    wait_cyc(85);
    check("pre_rst_dat", 32'(AUD_DACDAT), 32'd1);
    #1 Reset = 1'b1;
    #1;
    check_reset_values("async");
    @(negedge Clk);

    // Randomized traffic with occasional Enable toggles.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      sample_valid = ($urandom_range(0, (i < 1500) ? 150 : 3) == 0);
      sample_in    = sample_t'($urandom_range(0, 65535));
      if ($urandom_range(0, 399) == 0) Enable = !Enable;
      @(negedge Clk);
    end
    sample_valid = 1'b0;
    Enable = 1'b1;
    @(negedge Clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, giving Clk cycles per BCLK half-period (legal range 2..255).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, giving the sample FIFO depth (power of two, 4..64).
REQ-003 SHALL have port Clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port Enable, input, 1 bit: transmit audio when high; send zeros and flush the FIFO when low.
REQ-006 SHALL have port sample_in, input, 16 bits: signed mono audio sample.
REQ-007 SHALL have port sample_valid, input, 1 bit: sample_in is valid.
REQ-008 SHALL have port sample_ready, output, 1 bit: the FIFO can accept a sample.
REQ-009 SHALL have port AUD_BCLK, output, 1 bit: I2S bit clock.
REQ-010 SHALL have port AUD_DACLRCK, output, 1 bit: I2S word select (0 = left, 1 = right).
REQ-011 SHALL have port AUD_DACDAT, output, 1 bit: I2S serial data.
REQ-012 SHALL have port underflow, output, 1 bit: one-Clk pulse when a frame starts with the FIFO empty.

Function
REQ-013 SHALL accept sample_in into the FIFO on a Clk edge where sample_valid && sample_ready; sample_ready = !fifo_full, combinational from registered state.
REQ-014 SHALL toggle AUD_BCLK every CLK_DIV Clk cycles, giving a 50% duty cycle with period 2*CLK_DIV.
REQ-015 SHALL keep a 5-bit slot counter that advances on each BCLK falling edge and wraps 31->0; AUD_DACLRCK is 0 for counts 0..15 and 1 for counts 16..31, changing only on BCLK falling edges.
REQ-016 SHALL pop one FIFO word when the counter wraps 31->0 (frame start) and send that word on both channels.
REQ-017 SHALL, on frame start with the FIFO empty, send 0x0000 for that frame, pulse underflow, and leave FIFO state unchanged.
REQ-018 SHALL follow I2S timing: channel word bit (15-j) is driven during the (j+1)th BCLK period after the LRCK edge, j = 0..15; the LSB occupies the first period of the next slot; AUD_DACDAT changes only on BCLK falling edges.
REQ-019 SHALL, if a push and a pop occur in the same Clk cycle, perform both; occupancy stays constant and a full FIFO stays full.
REQ-020 SHALL silently refuse pushes when full (sample_ready = 0), with no overwrite.
REQ-021 SHALL, while Enable = 0, keep BCLK/LRCK running, force the transmitted word to 0x0000, hold the FIFO empty, drive sample_ready = 0, and suppress underflow.
REQ-022 SHALL, when Enable rises, begin on the next frame start; a partial frame in progress finishes with zeros.

Reset
REQ-023 SHALL, while Reset = 1, asynchronously force AUD_BCLK = 0, AUD_DACLRCK = 1, AUD_DACDAT = 0, underflow = 0, slot counter = 31, divider = 0, FIFO empty, and sample_ready = 1 (if Enable = 1).
REQ-024 SHALL make the first BCLK falling edge after Reset release a frame start (counter 31->0).
REQ-025 SHALL, on Reset mid-frame, discard the partial frame and all buffered samples, with no glitch on outputs beyond the asynchronous forcing.

Configuration
REQ-026 SHALL, with macro I2S_TX_UNDERFLOW_CNT_EN defined, add output underflow_count (16 bits, saturating at 0xFFFF, cleared by Reset) that increments on each underflow pulse.
REQ-027 SHALL, without I2S_TX_UNDERFLOW_CNT_EN, omit the underflow_count port and counter; all other behaviour is identical.

Structure
REQ-028 SHALL place in shared package audio_pkg: typedef sample_t (signed 16-bit), constants I2S_SLOT_BITS = 16 and I2S_FRAME_BITS = 32.
REQ-029 SHALL implement the FIFO as sub-module sample_fifo (parameter DEPTH, ports push/pop/din/dout/full/empty), instantiated once.

Verification
REQ-030 SHALL cover: after Reset, push 0x8001 with CLK_DIV = 4 -> the next frame shifts 1000_0000_0000_0001 on both slots, with the MSB one BCLK after LRCK falls.
REQ-031 SHALL cover: hold sample_valid = 1 without frames popping -> sample_ready drops after exactly 8 accepts; the 9th word is not stored.
REQ-032 SHALL cover: no samples pushed after Reset -> DACDAT stays 0 and underflow pulses once per 64*CLK_DIV Clk cycles; with I2S_TX_UNDERFLOW_CNT_EN, the count reaches 3 after 3 frames.
REQ-033 SHALL cover: FIFO holding one word, with push and pop in the same cycle -> occupancy stays 1 and the words are sent in order (0x1234 then 0xABCD).
REQ-034 SHALL cover: drop Enable mid-frame with 4 words buffered -> the remaining bits are 0, the FIFO is empty, sample_ready = 0, and there is no underflow pulse.
REQ-035 SHALL cover: assert Reset during the bit-7 slot of a frame -> outputs take reset values immediately, without waiting for a Clk edge.
